// File: rtl/fir_decim_pkg.sv
// Shared constants and types for the FIR output decimator.
// Defaults here match the low-pass FIR top-level configuration.
package fir_decim_pkg;

    localparam int DATA_W     = 17;
    localparam int DECIM      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DECIM_LOG2 = $clog2(DECIM);
    localparam int ACC_W      = DATA_W + DECIM_LOG2;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_out_decimator_if.sv
// Filter-side sample stream and consumer-side valid/ready stream.
// The slave modport is the decimator's view; master is the driver's view.
interface fir_out_decimator_if #(
    parameter int DATA_W     = 17,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LW-1:0]     fifo_level;
    logic              overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, fifo_level, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, fifo_level, overflow
    );
endinterface

// File: rtl/fir_out_decimator_sync_fifo.sv
// First-word fall-through FIFO with a registered head that holds its
// last value while empty. Push while full is ignored unless a pop coincides.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      level_q, level_d, lvl_left;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d     = wr_q + AW'(do_push);
        rd_d     = rd_q + AW'(do_pop);
        lvl_left = level_q - (AW+1)'(do_pop);
        level_d  = lvl_left + (AW+1)'(do_push);
        // Head after this edge: the entry at the new read pointer, or the
        // incoming word when it lands in an otherwise empty FIFO.
        if (lvl_left != '0)
            dout_d = mem[rd_d];
        else if (do_push)
            dout_d = din;
        else
            dout_d = dout_q;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            dout_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            dout_q  <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign level = level_q;
endmodule

// File: rtl/fir_out_decimator.sv
// Decimates the FIR output stream by DECIM and queues results for a consumer.
// FIR_DECIM_AVG_EN selects boxcar averaging instead of picking every DECIMth sample.
module fir_out_decimator
    import fir_decim_pkg::*;
#(
    parameter int DATA_W     = fir_decim_pkg::DATA_W,
    parameter int DECIM      = fir_decim_pkg::DECIM,
    parameter int FIFO_DEPTH = fir_decim_pkg::FIFO_DEPTH
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    fir_out_decimator_if.slave  bus
);
    localparam int LOG2 = $clog2(DECIM);

    logic [LOG2-1:0]   phase_q, phase_d;
    logic              emit, pop, full, empty;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] push_data;

    assign emit    = bus.in_valid && (phase_q == LOG2'(DECIM - 1));
    assign pop     = bus.out_ready && !empty;
    assign phase_d = bus.in_valid ? phase_q + LOG2'(1) : phase_q;
    // The filter cannot stall, so a full FIFO without a pop loses the sample.
    assign ovf_d   = ovf_q | (emit && full && !pop);

`ifdef FIR_DECIM_AVG_EN
    localparam int AW = DATA_W + LOG2;

    logic signed [AW-1:0] acc_q, acc_d, ext, sum;

    always_comb begin
        ext   = {{LOG2{bus.in_data[DATA_W-1]}}, bus.in_data};
        sum   = (phase_q == '0) ? ext : acc_q + ext;
        acc_d = bus.in_valid ? sum : acc_q;
    end

    // Dropping the low LOG2 bits is the floor-rounded arithmetic shift.
    assign push_data = sum[AW-1:LOG2];

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end
`else
    assign push_data = bus.in_data;
`endif

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk_100MHz),
        .rst_n (reset),
        .push  (emit),
        .pop   (pop),
        .din   (push_data),
        .dout  (bus.out_data),
        .full  (full),
        .empty (empty),
        .level (bus.fifo_level)
    );

    assign bus.out_valid = !empty;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fir_out_decimator.sv
// Scoreboard bench for fir_out_decimator: stimulus pushes expected samples,
// a negedge monitor pops and compares them on every handshake.
module tb_fir_out_decimator;
    import fir_decim_pkg::*;

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_out_decimator_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    fir_out_decimator #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    int    errors = 0;
    int    checks = 0;
    word_t exp_q[$];
    int    m_phase = 0;
    longint m_sum = 0;

`ifdef FIR_DECIM_AVG_EN
    localparam word_t E_P4   = 17'h00002;
    localparam word_t E_P8   = 17'h00006;
    localparam word_t E_A2   = 17'h00002;
    localparam word_t E_GAP  = 17'h00002;
    localparam word_t E_RST  = 17'h0000B;
`else
    localparam word_t E_P4   = 17'h00004;
    localparam word_t E_P8   = 17'h00008;
    localparam word_t E_A2   = 17'h00004;
    localparam word_t E_GAP  = 17'h00004;
    localparam word_t E_RST  = 17'h0000D;
`endif

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one valid input for one edge; model the expected emission.
    task automatic send(input word_t v);
        sample_t sv;
        word_t   e;
        sv = v;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        if (m_phase == 0) m_sum = longint'(sv);
        else              m_sum = m_sum + longint'(sv);
        if (m_phase == DECIM - 1) begin
`ifdef FIR_DECIM_AVG_EN
            e = word_t'(m_sum >>> DECIM_LOG2);
`else
            e = v;
`endif
            if (!(exp_q.size() >= FIFO_DEPTH && !bus.out_ready))
                exp_q.push_back(e);
        end
        m_phase = (m_phase + 1) % DECIM;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", word_t'(exp_q.size()), '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected none",
                         bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = i[0];
            bus.in_data  = word_t'(i + 7);
            @(negedge clk);
            chk("rst_valid", word_t'(bus.out_valid), '0);
            chk("rst_data", bus.out_data, '0);
            chk("rst_level", word_t'(bus.fifo_level), '0);
            chk("rst_ovf", word_t'(bus.overflow), '0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        for (int v = 1; v <= 8; v++) begin
            send(word_t'(v));
            if (v == 4) begin
                chk("lat_valid4", word_t'(bus.out_valid), 1);
                chk("lat_data4", bus.out_data, E_P4);
            end
            if (v == 8) begin
                chk("lat_valid8", word_t'(bus.out_valid), 1);
                chk("lat_data8", bus.out_data, E_P8);
            end
        end
        idle(3);
        chk("pick_none_left", word_t'(exp_q.size()), '0);

        repeat (4) send(17'h1FFFF);
        chk("neg1_out", bus.out_data, 17'h1FFFF);
        for (int v = 1; v <= 4; v++) send(word_t'(v));
        chk("ramp_out", bus.out_data, E_A2);
        repeat (4) send(17'h10000);
        chk("minval_out", bus.out_data, 17'h10000);
        idle(3);

        bus.out_ready = 1'b0;
        for (int v = 1; v <= 36; v++) send(word_t'(v));
        chk("bp_level", word_t'(bus.fifo_level), word_t'(FIFO_DEPTH));
        chk("bp_ovf", word_t'(bus.overflow), 1);
        chk("bp_queued", word_t'(exp_q.size()), word_t'(FIFO_DEPTH));
        bus.out_ready = 1'b1;
        drain(40);
        idle(3);
        chk("bp_empty", word_t'(bus.fifo_level), '0);
        chk("bp_ovf_sticky", word_t'(bus.overflow), 1);

        send(1);
        idle(1);
        send(2);
        idle(2);
        send(3);
        send(4);
        chk("gap_valid", word_t'(bus.out_valid), 1);
        chk("gap_data", bus.out_data, E_GAP);
        idle(3);

        bus.out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) send(word_t'(v));
        chk("mid_level", word_t'(bus.fifo_level), 1);
        rst_n = 1'b0;
        exp_q.delete();
        m_phase = 0;
        @(negedge clk);
        chk("mid_rst_valid", word_t'(bus.out_valid), '0);
        chk("mid_rst_level", word_t'(bus.fifo_level), '0);
        chk("mid_rst_ovf", word_t'(bus.overflow), '0);
        chk("mid_rst_data", bus.out_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(1);
        for (int v = 10; v <= 13; v++) send(word_t'(v));
        chk("mid_valid", word_t'(bus.out_valid), 1);
        chk("mid_data", bus.out_data, E_RST);
        idle(4);
        chk("final_empty", word_t'(exp_q.size()), '0);
        chk("final_level", word_t'(bus.fifo_level), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
